// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: phase sequencer for the multicycle CPU core.
// Steps each instruction through IF, ID, EX, MEM, WB, PCPL and back to IF,
// and drives the per-phase enables that qualify the control decoder's bits.
//
// Memory handshake (mem_req / mem_ready): a transfer completes on the rising
// edge where mem_req and mem_ready are both high. mem_req stays high until
// that edge, mem_ready is ignored whenever mem_req is low, and there is no
// timeout. Reset abandons any outstanding request without a handshake.

`ifndef Rformat
`define Rformat 6'b000000
`endif
`ifndef OPC_ADDI
`define OPC_ADDI 6'b001000
`endif
`ifndef OPC_ADDIU
`define OPC_ADDIU 6'b001001
`endif
`ifndef OPC_LDRW
`define OPC_LDRW 6'b100011
`endif
`ifndef OPC_STRW
`define OPC_STRW 6'b101011
`endif
`ifndef OPC_BEQ
`define OPC_BEQ 6'b000100
`endif
`ifndef OPC_BNE
`define OPC_BNE 6'b000101
`endif
`ifndef OPC_BLEZ
`define OPC_BLEZ 6'b000110
`endif
`ifndef OPC_JUMP
`define OPC_JUMP 6'b000010
`endif

module multicycle_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        power,
  input  logic [5:0]  op,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        illegal,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_PCPL = 3'd5,
    S_BAD6 = 3'd6,
    S_BAD7 = 3'd7
  } state_t;

  state_t      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [15:0] retired_q, retired_d;

  logic op_branch;
  logic op_load;
  logic op_store;
  logic op_alu;
  logic op_known;

  // Opcode classification; op is held stable by the core from ID to PCPL exit.
  always_comb begin
    op_branch = (op == `OPC_BEQ) || (op == `OPC_BNE) || (op == `OPC_BLEZ) || (op == `OPC_JUMP);
    op_load   = (op == `OPC_LDRW);
    op_store  = (op == `OPC_STRW);
    op_alu    = (op == `Rformat) || (op == `OPC_ADDI) || (op == `OPC_ADDIU);
    op_known  = op_branch || op_load || op_store || op_alu;
  end

  // State, sticky illegal flag and retire counter; reset wins over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic, sticky illegal, retire count and phase enables.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;

    case (state_q)
      S_IF: begin
        // power only gates the start of a fetch; it never aborts later phases.
        mem_req  = power;
        ir_write = power & mem_ready;
        if (power && mem_ready) state_d = S_ID;
      end
      S_ID: begin
        if (op_known) begin
          state_d = S_EX;
        end else begin
          // Unknown opcodes retire as no-ops straight through PCPL.
          state_d   = S_PCPL;
          illegal_d = 1'b1;
        end
      end
      S_EX: begin
        if (op_branch)                 state_d = S_PCPL;
        else if (op_load || op_store)  state_d = S_MEM;
        else                           state_d = S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = op_store;
        if (mem_ready) state_d = op_load ? S_WB : S_PCPL;
      end
      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_PCPL;
      end
      S_PCPL: begin
        pc_write  = 1'b1;
        state_d   = S_IF;
        retired_d = retired_q + 16'd1;
      end
      default: begin
        // Encodings 6 and 7 are never entered normally; recover to fetch.
        state_d = S_IF;
      end
    endcase
  end

  assign state   = state_q;
  assign illegal = illegal_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-cycle scoreboard of all outputs plus
// instruction latency checks.
module tb_multicycle_sequencer;

  localparam logic [5:0] OP_RFORMAT = 6'b000000;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LDRW    = 6'b100011;
  localparam logic [5:0] OP_STRW    = 6'b101011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] OP_BLEZ    = 6'b000110;
  localparam logic [5:0] OP_JUMP    = 6'b000010;
  localparam logic [5:0] OP_BAD     = 6'h3F;

  localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2,
                         ST_MEM = 3'd3, ST_WB = 3'd4, ST_PCPL = 3'd5;

  localparam int W = 25;

  logic        clk;
  logic        reset;
  logic        power;
  logic [5:0]  op;
  logic        mem_ready;
  logic [2:0]  state;
  logic        mem_req;
  logic        mem_we;
  logic        ir_write;
  logic        reg_write;
  logic        pc_write;
  logic        illegal;
  logic [15:0] retired;

  multicycle_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .power     (power),
    .op        (op),
    .mem_ready (mem_ready),
    .state     (state),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ir_write  (ir_write),
    .reg_write (reg_write),
    .pc_write  (pc_write),
    .illegal   (illegal),
    .retired   (retired)
  );

  // Clock and global time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "time limit");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model of the sequencer as seen from its ports
  logic [2:0]  m_state;
  logic        m_illegal;
  logic [15:0] m_retired;
  logic [W-1:0] exp_q[$];

  function automatic bit is_known(input logic [5:0] o);
    return (o == OP_RFORMAT) || (o == OP_ADDI) || (o == OP_ADDIU) ||
           (o == OP_LDRW) || (o == OP_STRW) || (o == OP_BEQ) ||
           (o == OP_BNE) || (o == OP_BLEZ) || (o == OP_JUMP);
  endfunction

  function automatic logic [2:0] model_next(input logic [2:0] s, input logic pw,
                                            input logic rdy, input logic [5:0] o);
    case (s)
      ST_IF:   return (pw && rdy) ? ST_ID : ST_IF;
      ST_ID:   return is_known(o) ? ST_EX : ST_PCPL;
      ST_EX: begin
        if (o == OP_LDRW || o == OP_STRW) return ST_MEM;
        if (o == OP_RFORMAT || o == OP_ADDI || o == OP_ADDIU) return ST_WB;
        return ST_PCPL;
      end
      ST_MEM:  return rdy ? ((o == OP_LDRW) ? ST_WB : ST_PCPL) : ST_MEM;
      ST_WB:   return ST_PCPL;
      default: return ST_IF;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_vec(input logic pw, input logic rdy, input logic [5:0] o);
    logic e_req, e_we, e_ir, e_rw, e_pc;
    e_req = ((m_state == ST_IF) && pw) || (m_state == ST_MEM);
    e_we  = (m_state == ST_MEM) && (o == OP_STRW);
    e_ir  = (m_state == ST_IF) && pw && rdy;
    e_rw  = (m_state == ST_WB);
    e_pc  = (m_state == ST_PCPL);
    return {m_state, e_req, e_we, e_ir, e_rw, e_pc, m_illegal, m_retired};
  endfunction

  // Scoreboard: compare one expected vector per cycle, away from the edge
  always @(negedge clk) begin
    logic [W-1:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("cycle", {7'd0, state, mem_req, mem_we, ir_write, reg_write, pc_write, illegal, retired},
          {7'd0, e});
    end
  end

  // Idle cycles with power low; mem_ready toggles randomly and must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset     = 1'b0;
      power     = 1'b0;
      mem_ready = 1'($urandom_range(0, 1));
      exp_q.push_back(exp_vec(power, mem_ready, op));
    end
  endtask

  // Drive one instruction from IF until it leaves PCPL (or reset in MEM)
  task automatic run_instr(input logic [5:0] opc, input int if_wait, input int mem_wait,
                           input int exp_cycles, input bit drop_pwr, input bit rst_in_mem);
    int if_cnt = 0;
    int mem_cnt = 0;
    int cycles = 0;
    bit done = 0;
    logic [2:0] nxt;
    while (!done && cycles < 64) begin
      @(negedge clk);
      op = opc;
      if (cycles == 0) power = 1'b1;
      if (drop_pwr && m_state == ST_EX) power = 1'b0;
      case (m_state)
        ST_IF: begin
          mem_ready = (if_cnt >= if_wait);
          if_cnt++;
        end
        ST_MEM: begin
          mem_ready = (mem_cnt >= mem_wait);
          mem_cnt++;
        end
        default: mem_ready = 1'($urandom_range(0, 1));
      endcase
      exp_q.push_back(exp_vec(power, mem_ready, op));
      cycles++;
      if (rst_in_mem && m_state == ST_MEM && mem_cnt == 2) begin
        reset     = 1'b1;
        m_state   = ST_IF;
        m_illegal = 1'b0;
        m_retired = 16'h0000;
        done      = 1;
      end else begin
        nxt = model_next(m_state, power, mem_ready, op);
        if (m_state == ST_ID && !is_known(op)) m_illegal = 1'b1;
        if (m_state == ST_PCPL) begin
          m_retired = m_retired + 16'd1;
          done = 1;
        end
        m_state = nxt;
      end
    end
    if (exp_cycles != 0) chk("latency", cycles, exp_cycles);
  endtask

  initial begin
    reset     = 1'b1;
    power     = 1'b0;
    op        = OP_RFORMAT;
    mem_ready = 1'b0;
    m_state   = ST_IF;
    m_illegal = 1'b0;
    m_retired = 16'h0000;
    repeat (2) @(posedge clk);

    // Reset state, power low: everything idle
    idle(3);

    // ALU with zero-wait memory: 0,1,2,4,5 then IF
    run_instr(OP_RFORMAT, 0, 0, 5, 0, 0);
    // Load with three memory wait cycles
    run_instr(OP_LDRW, 0, 3, 9, 0, 0);
    // Store then branch back to back
    run_instr(OP_STRW, 0, 0, 5, 0, 0);
    run_instr(OP_BEQ, 0, 0, 4, 0, 0);
    // Remaining opcodes, with fetch and memory waits
    run_instr(OP_ADDI, 2, 0, 7, 0, 0);
    run_instr(OP_ADDIU, 0, 0, 5, 0, 0);
    run_instr(OP_BNE, 1, 0, 5, 0, 0);
    run_instr(OP_BLEZ, 0, 0, 4, 0, 0);
    run_instr(OP_JUMP, 0, 0, 4, 0, 0);
    run_instr(OP_STRW, 0, 1, 6, 0, 0);
    idle(2);

    // Unknown opcode, then illegal stays set across a normal instruction
    run_instr(OP_BAD, 0, 0, 3, 0, 0);
    run_instr(OP_RFORMAT, 0, 0, 5, 0, 0);

    // Power dropped during EX: instruction completes, then parks in IF
    run_instr(OP_ADDI, 0, 0, 5, 1, 0);
    idle(3);

    // Reset while waiting in MEM with mem_req high
    run_instr(OP_LDRW, 0, 10, 0, 0, 1);
    idle(3);

    // Counter wrap: preload near the top, then retire two branches
    @(negedge clk);
    force dut.retired_q = 16'hFFFE;
    #1;
    release dut.retired_q;
    reset     = 1'b0;
    power     = 1'b0;
    mem_ready = 1'b0;
    m_retired = 16'hFFFE;
    exp_q.push_back(exp_vec(power, mem_ready, op));
    run_instr(OP_BEQ, 0, 0, 4, 0, 0);
    run_instr(OP_BEQ, 0, 0, 4, 0, 0);
    idle(2);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #3;
    chk("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
